pe_row_conv: RTL and testbench
==============================

PE_ROW_CONV -- requirements
Module: pe_row_conv

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the width of signed iact and weight words.
REQ-002 SHALL have parameter ACC_W, default 40, the width of signed accumulator, psum and output words.
REQ-003 SHALL have parameter IACT_LEN, default 5, the number of iact words per row (range 2..64).
REQ-004 SHALL have parameter KERNEL_LEN, default 3, the number of weight words per row (range 1..IACT_LEN); OUT_LEN = IACT_LEN-KERNEL_LEN+1 is derived.
REQ-005 SHALL use one clock; reset is asynchronous and active-high; ports: clk  in  1  clock (rising edge); rst  in  1  async active-high reset.
REQ-006 start  in  1  begin a row operation; sampled only in IDLE.
REQ-007 wgt_reuse  in  1  sampled with start; 1 = skip weight load and reuse stored kernel.
REQ-008 acc_en  in  1  sampled with start; 1 = add external psum to each output.
REQ-009 iact_valid/iact_ready  in/out  1/1  iact stream handshake; iact_data  in  DATA_W.
REQ-010 wgt_valid/wgt_ready  in/out  1/1  weight stream handshake; wgt_data  in  DATA_W.
REQ-011 psum_valid/psum_ready  in/out  1/1  psum stream handshake; psum_data  in  ACC_W.
REQ-012 out_valid/out_ready  out/in  1/1  result stream handshake; out_data  out  ACC_W.
REQ-013 busy  out  1  high in every state except IDLE; done  out  1  single-cycle pulse at end of row.

Function
REQ-014 SHALL implement states IDLE, LOAD_IACT, LOAD_WGT, COMPUTE, DRAIN, DONE.
REQ-015 IDLE: start=1 latches wgt_reuse/acc_en and goes to LOAD_IACT next cycle; start ignored in every other state.
REQ-016 LOAD_IACT: iact_ready=1; each cycle with iact_valid&iact_ready stores iact_data at index 0,1,...; after IACT_LEN transfers goes to LOAD_WGT, or to COMPUTE if latched wgt_reuse=1 and a kernel has been loaded since reset.
REQ-017 wgt_reuse=1 with no kernel loaded since reset SHALL be treated as wgt_reuse=0.
REQ-018 LOAD_WGT: wgt_ready=1; stores KERNEL_LEN words at index 0..KERNEL_LEN-1, then goes to COMPUTE; the kernel-loaded flag is set.
REQ-019 iact_ready and wgt_ready SHALL be 0 outside their load states; excess beats are not accepted.
REQ-020 COMPUTE: one signed MAC per cycle, acc[o] += iact[o+k]*wgt[k], o=0..OUT_LEN-1, k=0..KERNEL_LEN-1, k innermost; exactly OUT_LEN*KERNEL_LEN cycles; every acc[o] cleared on COMPUTE entry; then DRAIN.
REQ-021 Products SHALL be full 2*DATA_W signed, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W (no saturation).
REQ-022 DRAIN: presents acc[0..OUT_LEN-1] in order; with acc_en=0, out_valid=1 and out_data=acc[i]; with acc_en=1, out_valid=psum_valid, psum_ready=out_ready, out_data=acc[i]+psum_data (wrapping).
REQ-023 Index i SHALL advance only on out_valid&out_ready; out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 After the OUT_LEN-th output handshake, the block SHALL go to DONE, assert done for one cycle, and return to IDLE.
REQ-025 psum_ready SHALL be 0 outside DRAIN and in DRAIN when acc_en=0.
REQ-026 Stored iact words SHALL be overwritten per row; stored weights SHALL persist across rows until the next LOAD_WGT.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, clear counters, acc, kernel-loaded flag and latched modes, and drive busy, done, out_valid, iact_ready, wgt_ready, psum_ready and out_data to 0.
REQ-028 Reset mid-operation SHALL abort the row with no done pulse; the next start requires a full weight load.

Verification
REQ-029 Defaults; iact 1,2,3,4,5; wgt 1,0,-1; out_ready=1 -> outputs -2,-2,-2; done one cycle; COMPUTE lasts 9 cycles.
REQ-030 Second row with wgt_reuse=1; iact 5,4,3,2,1 -> no wgt_ready assertion; outputs 2,2,2.
REQ-031 acc_en=1; psum 10,20,30 with psum_valid gaps; same row as REQ-029 -> outputs 8,18,28, each emitted only on a psum beat.
REQ-032 out_ready toggled 0/1 during DRAIN -> out_data stable while stalled; no output lost or duplicated.
REQ-033 DATA_W=8, ACC_W=16, iact all -128, wgt all -128 -> each output 49152 mod 2^16 = -16384 (wrap checked).
REQ-034 rst pulsed during COMPUTE, then start with wgt_reuse=1 -> all outputs 0 during reset; weights reloaded; results correct for the new row.

Source files
------------

// File: rtl/pe_row_conv.sv
// pe_row_conv -- one row of a 1-D convolution processing element.
//
// Loads a row of IACT_LEN activations, optionally a fresh kernel of
// KERNEL_LEN weights, runs one signed MAC per cycle to build
// OUT_LEN = IACT_LEN-KERNEL_LEN+1 partial sums, then streams them out,
// optionally adding an incoming psum stream word by word.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   start, wgt_reuse, acc_en       row command; modes sampled with start in IDLE
//   iact_valid/ready/data          activation stream (DATA_W, signed)
//   wgt_valid/ready/data           weight stream (DATA_W, signed)
//   psum_valid/ready/data          incoming partial sums (ACC_W, signed)
//   out_valid/ready/data           result stream (ACC_W, signed)
//   busy, done                     busy = not IDLE; done = 1-cycle end-of-row pulse
module pe_row_conv #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int IACT_LEN   = 5,
  parameter int KERNEL_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wgt_reuse,
  input  logic              acc_en,
  input  logic              iact_valid,
  output logic              iact_ready,
  input  logic [DATA_W-1:0] iact_data,
  input  logic              wgt_valid,
  output logic              wgt_ready,
  input  logic [DATA_W-1:0] wgt_data,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [ACC_W-1:0]  psum_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);

  localparam int OUT_LEN = IACT_LEN - KERNEL_LEN + 1;
  localparam int IW = (IACT_LEN   > 1) ? $clog2(IACT_LEN)   : 1;
  localparam int KW = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int OW = (OUT_LEN    > 1) ? $clog2(OUT_LEN)    : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_IACT = 3'd1;
  localparam logic [2:0] S_LOAD_WGT  = 3'd2;
  localparam logic [2:0] S_COMPUTE   = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]    state;
  logic [IW-1:0] cnt;     // load index, then drain index
  logic [OW-1:0] o_idx;
  logic [KW-1:0] k_idx;
  logic          reuse_q, acc_en_q, kload_q;

  logic signed [DATA_W-1:0]   iact_mem [IACT_LEN];
  logic signed [DATA_W-1:0]   wgt_mem  [KERNEL_LEN];
  logic signed [ACC_W-1:0]    acc      [OUT_LEN];
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    drain_acc;

  logic iact_hs, wgt_hs, out_hs;
  logic last_iact, last_wgt, last_out, last_k, last_o;

  assign iact_ready = (state == S_LOAD_IACT);
  assign wgt_ready  = (state == S_LOAD_WGT);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // With accumulation the output beat is just the psum beat passed through,
  // so psum is consumed exactly when the sum is taken downstream.
  assign out_valid  = (state == S_DRAIN) && (acc_en_q ? psum_valid : 1'b1);
  assign psum_ready = (state == S_DRAIN) && acc_en_q && out_ready;

  assign drain_acc = acc[OW'(cnt)];
  assign out_data  = (state != S_DRAIN) ? '0 :
                     acc_en_q ? drain_acc + psum_data : drain_acc;

  assign iact_hs = iact_valid && iact_ready;
  assign wgt_hs  = wgt_valid && wgt_ready;
  assign out_hs  = out_valid && out_ready;

  assign last_iact = (cnt == IW'(IACT_LEN - 1));
  assign last_wgt  = (cnt == IW'(KERNEL_LEN - 1));
  assign last_out  = (cnt == IW'(OUT_LEN - 1));
  assign last_k    = (k_idx == KW'(KERNEL_LEN - 1));
  assign last_o    = (o_idx == OW'(OUT_LEN - 1));

  // Full-precision product; sign-extended into the accumulator below.
  assign prod = iact_mem[IW'(o_idx) + IW'(k_idx)] * wgt_mem[k_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      o_idx    <= '0;
      k_idx    <= '0;
      reuse_q  <= 1'b0;
      acc_en_q <= 1'b0;
      kload_q  <= 1'b0;
      for (int i = 0; i < OUT_LEN; i++) acc[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          reuse_q  <= wgt_reuse;
          acc_en_q <= acc_en;
          cnt      <= '0;
          state    <= S_LOAD_IACT;
        end
        S_LOAD_IACT: if (iact_hs) begin
          if (last_iact) begin
            cnt <= '0;
            // Reuse only honoured once a kernel actually exists.
            if (reuse_q && kload_q) begin
              state <= S_COMPUTE;
              o_idx <= '0;
              k_idx <= '0;
              for (int i = 0; i < OUT_LEN; i++) acc[i] <= '0;
            end else begin
              state <= S_LOAD_WGT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOAD_WGT: if (wgt_hs) begin
          if (last_wgt) begin
            cnt     <= '0;
            kload_q <= 1'b1;
            state   <= S_COMPUTE;
            o_idx   <= '0;
            k_idx   <= '0;
            for (int i = 0; i < OUT_LEN; i++) acc[i] <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          acc[o_idx] <= acc[o_idx] + ACC_W'(prod);
          if (last_k) begin
            k_idx <= '0;
            o_idx <= o_idx + 1'b1;
            if (last_o) begin
              state <= S_DRAIN;
              cnt   <= '0;
            end
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        S_DRAIN: if (out_hs) begin
          if (last_out) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand storage needs no reset: it is always written before use.
  always_ff @(posedge clk) begin
    if (iact_hs) iact_mem[cnt]       <= iact_data;
    if (wgt_hs)  wgt_mem[KW'(cnt)]   <= wgt_data;
  end

endmodule

// File: tb/tb_pe_row_conv.sv
// Bench for pe_row_conv: directed table rows, a mid-compute reset sequence and
// randomized rows checked against a plain-arithmetic convolution model.
// A second 8/16-bit instance shares the control stream and checks wraparound.
module tb_pe_row_conv;

  typedef logic [4:0][15:0] ia_t;
  typedef logic [2:0][15:0] wg_t;
  typedef logic [2:0][39:0] ov_t;
  typedef struct packed {
    ia_t  ia;
    wg_t  wg;
    logic reuse;
    logic acc;
    ov_t  ps;
    ov_t  exp;
    logic wload;
    logic stall;
    logic gaps;
  } vec_t;

  logic        clk = 0, rst = 1, start = 0, wgt_reuse = 0, acc_en = 0;
  logic        iact_valid = 0, wgt_valid = 0, psum_valid = 0, out_ready = 0;
  logic [15:0] iact_data = '0, wgt_data = '0;
  logic [39:0] psum_data = '0;
  logic        iact_ready, wgt_ready, psum_ready, out_valid, busy, done;
  logic [39:0] out_data;

  logic [7:0]  iact_data8 = 8'h80, wgt_data8 = 8'h80;
  logic [15:0] psum_data8 = '0;
  logic        iact_ready8, wgt_ready8, psum_ready8, out_valid8, busy8, done8;
  logic [15:0] out_data8;

  always #5 clk = ~clk;

  pe_row_conv u_dut (
    .clk(clk), .rst(rst), .start(start), .wgt_reuse(wgt_reuse), .acc_en(acc_en),
    .iact_valid(iact_valid), .iact_ready(iact_ready), .iact_data(iact_data),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  pe_row_conv #(.DATA_W(8), .ACC_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .wgt_reuse(wgt_reuse), .acc_en(acc_en),
    .iact_valid(iact_valid), .iact_ready(iact_ready8), .iact_data(iact_data8),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready8), .wgt_data(wgt_data8),
    .psum_valid(psum_valid), .psum_ready(psum_ready8), .psum_data(psum_data8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .busy(busy8), .done(done8)
  );

  int  n_chk = 0, n_pass = 0;
  wg_t m_wgt = '0;
  bit  m_kl = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Direct sliding-window dot product, wrapped to 40 bits.
  function automatic ov_t model(input ia_t ia, input wg_t wg, input bit acc, input ov_t ps);
    ov_t    r;
    longint s;
    r = '0;
    for (int o = 0; o < 3; o++) begin
      s = 0;
      for (int k = 0; k < 3; k++)
        s += longint'($signed(ia[o+k])) * longint'($signed(wg[k]));
      if (acc) s += longint'($signed(ps[o]));
      r[o] = s[39:0];
    end
    return r;
  endfunction

  task automatic run_row(input string tag, input ia_t ia, input wg_t wg, input bit reuse,
                         input bit acc, input ov_t ps, input bit stall, input bit gaps,
                         input ov_t exp, input bit exp_wload);
    int ii, wi, pi, ng, cyc, comp, ndone;
    bit saw_w, extra, psync, stalled, ps_taken;
    logic [39:0] held;
    ov_t got;
    ii = 0; wi = 0; pi = 0; ng = 0; cyc = 0; comp = 0; ndone = 0;
    saw_w = 0; extra = 0; psync = 0; stalled = 0; ps_taken = 0; held = '0; got = '0;
    @(negedge clk); start = 1; wgt_reuse = reuse; acc_en = acc;
    @(negedge clk); start = 0; wgt_reuse = 0; acc_en = 0;
    while (ng < 3 && cyc < 300) begin
      iact_valid = (ii < 5);
      iact_data  = ia[(ii < 5) ? ii : 0];
      wgt_valid  = (wi < 3);
      wgt_data   = wg[(wi < 3) ? wi : 0];
      if (!psum_valid || ps_taken) begin
        psum_valid = acc && (pi < 3) && (!gaps || $urandom_range(0, 2) == 0);
        psum_data  = ps[(pi < 3) ? pi : 0];
      end
      ps_taken  = 0;
      out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (stalled) begin
        check({tag, " stall valid"}, out_valid, 1);
        check({tag, " stall data"}, out_data, held);
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (wgt_ready) saw_w = 1;
      if ((iact_ready && ii >= 5) || (wgt_ready && wi >= 3)) extra = 1;
      if (acc && ((psum_valid && psum_ready) != (out_valid && out_ready))) psync = 1;
      if (!acc && psum_ready) psync = 1;
      if (done) ndone++;
      if (busy && !iact_ready && !wgt_ready && !out_valid && !psum_ready && !done) comp++;
      if (iact_valid && iact_ready) ii++;
      if (wgt_valid && wgt_ready) wi++;
      if (out_valid && out_ready) begin
        got[ng] = out_data;
        check({tag, " dut8 wrap"}, {out_valid8, out_data8}, {1'b1, 16'hC000});
        ng++;
        if (acc) begin pi++; ps_taken = 1; end
      end
      @(negedge clk);
      cyc++;
    end
    iact_valid = 0; wgt_valid = 0; psum_valid = 0; out_ready = 1;
    repeat (3) begin
      #1;
      if (done) ndone++;
      @(negedge clk);
    end
    check({tag, " out count"}, ng, 3);
    for (int o = 0; o < 3; o++) check($sformatf("%s out%0d", tag, o), got[o], exp[o]);
    check({tag, " done pulses"}, ndone, 1);
    check({tag, " wgt load"}, saw_w, exp_wload);
    check({tag, " excess ready"}, extra, 0);
    check({tag, " psum sync"}, psync, 0);
    if (!(acc && stall)) check({tag, " compute cycles"}, comp, 9);
    check({tag, " idle after"}, busy, 0);
  endtask

  // Keeps the model's kernel state in step with what the row does.
  task automatic do_row(input string tag, input ia_t ia, input wg_t wg, input bit reuse,
                        input bit acc, input ov_t ps, input bit stall, input bit gaps,
                        input bit use_exp, input ov_t exp_in, input bit wload_in);
    bit  wl;
    ov_t exp;
    wl = !(reuse && m_kl);
    if (wl) begin m_wgt = wg; m_kl = 1; end
    exp = use_exp ? exp_in : model(ia, m_wgt, acc, ps);
    run_row(tag, ia, wg, reuse, acc, ps, stall, gaps, exp, use_exp ? wload_in : wl);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " iact_ready"}, iact_ready, 0);
    check({tag, " wgt_ready"}, wgt_ready, 0);
    check({tag, " psum_ready"}, psum_ready, 0);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " dut8 outs"},
          {busy8, done8, out_valid8, iact_ready8, wgt_ready8, psum_ready8, out_data8}, 0);
  endtask

  vec_t tbl [4];

  initial begin
    int  ii, wi, cyc;
    ia_t ria;
    wg_t rwg;
    ov_t rps;

    for (int t = 0; t < 4; t++) tbl[t] = '0;
    for (int i = 0; i < 5; i++) begin
      tbl[0].ia[i] = 16'(i + 1);
      tbl[1].ia[i] = 16'(5 - i);
      tbl[2].ia[i] = 16'(i + 1);
      tbl[3].ia[i] = 16'(i + 1);
    end
    tbl[0].wg[0] = 16'd1; tbl[0].wg[1] = 16'd0; tbl[0].wg[2] = 16'hFFFF;
    tbl[0].wload = 1;
    for (int k = 0; k < 3; k++) begin
      tbl[1].wg[k] = 16'h7777;
      tbl[2].wg[k] = 16'h7777;
      tbl[3].wg[k] = 16'h7777;
      tbl[0].exp[k] = 40'(-2);
      tbl[1].exp[k] = 40'd2;
      tbl[3].exp[k] = 40'(-2);
    end
    tbl[1].reuse = 1;
    tbl[2].reuse = 1; tbl[2].acc = 1; tbl[2].gaps = 1;
    tbl[2].ps[0] = 40'd10; tbl[2].ps[1] = 40'd20; tbl[2].ps[2] = 40'd30;
    tbl[2].exp[0] = 40'd8; tbl[2].exp[1] = 40'd18; tbl[2].exp[2] = 40'd28;
    tbl[3].reuse = 1; tbl[3].stall = 1;

    rst = 1;
    repeat (2) @(negedge clk);
    #1 reset_checks("reset");
    rst = 0;

    for (int t = 0; t < 4; t++)
      do_row($sformatf("tbl%0d", t), tbl[t].ia, tbl[t].wg, tbl[t].reuse, tbl[t].acc,
             tbl[t].ps, tbl[t].stall, tbl[t].gaps, 1'b1, tbl[t].exp, tbl[t].wload);

    // Abort a row part-way through COMPUTE.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    ii = 0; wi = 0; cyc = 0;
    while (wi < 3 && cyc < 100) begin
      iact_valid = (ii < 5); iact_data = 16'(ii + 7);
      wgt_valid  = (wi < 3); wgt_data  = 16'(wi + 3);
      #1;
      if (iact_valid && iact_ready) ii++;
      if (wgt_valid && wgt_ready) wi++;
      @(negedge clk);
      cyc++;
    end
    check("abort load", wi, 3);
    iact_valid = 0; wgt_valid = 0;
    @(negedge clk);
    #1 check("abort busy", busy, 1);
    rst = 1;
    #1 reset_checks("midreset");
    @(negedge clk);
    #1 reset_checks("midreset hold");
    rst = 0;
    m_kl = 0;
    for (int i = 0; i < 5; i++) ria[i] = 16'(2 * i - 3);
    rwg[0] = 16'd2; rwg[1] = 16'hFFFD; rwg[2] = 16'd5;
    do_row("post-reset", ria, rwg, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 5; i++) ria[i] = 16'($urandom);
      for (int k = 0; k < 3; k++) begin
        rwg[k] = 16'($urandom);
        rps[k] = 40'({$urandom, $urandom});
      end
      do_row($sformatf("rnd%0d", r), ria, rwg, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), rps, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
